// File: rtl/tcon_frame_crc_checker.sv
// tcon_frame_crc_checker
// Per-frame output checker for the TCON port. It builds a CRC-32 signature
// over the active pixels of each frame and checks the line length and line
// count. At every frame boundary it compares the signature with a value
// supplied by firmware. All results are registered and held until the next
// frame closes.
module tcon_frame_crc_checker #(
   parameter int DW     = 8,
   parameter int CH     = 3,
   parameter int WIDTH  = 1366,
   parameter int HEIGHT = 768,
   parameter int ECW    = 16
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              vsync,
   input  logic              de,
   input  logic [CH*DW-1:0]  pix_in,
   input  logic              chk_en,
   input  logic [31:0]       exp_crc,
   output logic              frame_done,
   output logic [31:0]       frame_crc,
   output logic              crc_err,
   output logic              size_err,
   output logic [15:0]       line_cnt,
   output logic [ECW-1:0]    err_frames
);

   localparam int             PW       = CH * DW;
   localparam logic [31:0]    CRC_POLY = 32'h04C1_1DB7;
   localparam logic [31:0]    CRC_INIT = 32'hFFFF_FFFF;
   localparam logic [15:0]    WIDTH_C  = 16'(WIDTH);
   localparam logic [15:0]    HEIGHT_C = 16'(HEIGHT);
   localparam logic [15:0]    CNT_MAX  = 16'hFFFF;
   localparam logic [ECW-1:0] ERR_MAX  = {ECW{1'b1}};

   typedef enum logic [0:0] {
      ST_IDLE   = 1'b0,
      ST_ACTIVE = 1'b1
   } state_t;

   // Fold one whole pixel into the CRC, most significant bit first.
   function automatic logic [31:0] crc_fold(input logic [31:0] crc_in,
                                            input logic [PW-1:0] data);
      logic [31:0] c;
      logic        fbk;
      c = crc_in;
      for (int i = PW - 1; i >= 0; i--) begin
         fbk = c[31] ^ data[i];
         c   = {c[30:0], 1'b0};
         if (fbk) begin
            c = c ^ CRC_POLY;
         end else begin
            c = c;
         end
      end
      return c;
   endfunction

   // Increment a 16-bit counter, holding it at all-ones.
   function automatic logic [15:0] sat_inc16(input logic [15:0] v);
      return (v == CNT_MAX) ? v : v + 16'd1;
   endfunction

   state_t          state_q, state_d;
   logic            vsync_dly_q, vsync_dly_d;
   logic            de_dly_q, de_dly_d;
   logic [31:0]     crc_q, crc_d;
   logic [15:0]     run_q, run_d;
   logic [15:0]     lines_q, lines_d;
   logic            size_flag_q, size_flag_d;
   logic            frame_done_q, frame_done_d;
   logic [31:0]     frame_crc_q, frame_crc_d;
   logic            crc_err_q, crc_err_d;
   logic            size_err_q, size_err_d;
   logic [15:0]     line_cnt_q, line_cnt_d;
   logic [ECW-1:0]  err_frames_q, err_frames_d;

   logic            fb_s;
   logic            line_end_s;
   logic [31:0]     crc_base_s;
   logic [31:0]     crc_next_s;
   logic [15:0]     lines_close_s;
   logic            size_close_s;
   logic            crc_bad_s;

   // Frame boundary, line end and the single CRC fold shared by all paths.
   // On a frame boundary the pixel starts a new frame, so it folds from init.
   always_comb begin
      fb_s          = vsync & ~vsync_dly_q;
      line_end_s    = de_dly_q & ~de;
      crc_base_s    = fb_s ? CRC_INIT : crc_q;
      crc_next_s    = crc_fold(crc_base_s, pix_in);
      lines_close_s = de_dly_q ? sat_inc16(lines_q) : lines_q;
      size_close_s  = size_flag_q
                    | (de_dly_q & (run_q != WIDTH_C))
                    | (lines_close_s != HEIGHT_C);
      crc_bad_s     = chk_en & (crc_q != exp_crc);
   end

   // Next-state logic: frame open/close, pixel accumulation and line checks.
   always_comb begin
      state_d      = state_q;
      vsync_dly_d  = vsync;
      de_dly_d     = 1'b0;
      crc_d        = crc_q;
      run_d        = run_q;
      lines_d      = lines_q;
      size_flag_d  = size_flag_q;
      frame_done_d = 1'b0;
      frame_crc_d  = frame_crc_q;
      crc_err_d    = crc_err_q;
      size_err_d   = size_err_q;
      line_cnt_d   = line_cnt_q;
      err_frames_d = err_frames_q;

      // de is only tracked once a frame is open, so IDLE traffic cannot
      // fake a line end in the first active cycle.
      if ((state_q == ST_ACTIVE) || fb_s) begin
         de_dly_d = de;
      end else begin
         de_dly_d = 1'b0;
      end

      case (state_q)
         ST_IDLE: begin
            if (fb_s) begin
               state_d     = ST_ACTIVE;
               crc_d       = de ? crc_next_s : CRC_INIT;
               run_d       = de ? 16'd1 : 16'd0;
               lines_d     = 16'd0;
               size_flag_d = 1'b0;
            end else begin
               state_d = ST_IDLE;
            end
         end
         ST_ACTIVE: begin
            if (fb_s) begin
               frame_done_d = 1'b1;
               frame_crc_d  = crc_q;
               line_cnt_d   = lines_close_s;
               size_err_d   = size_close_s;
               crc_err_d    = crc_bad_s;
               if ((crc_bad_s | size_close_s) && (err_frames_q != ERR_MAX)) begin
                  err_frames_d = err_frames_q + {{(ECW-1){1'b0}}, 1'b1};
               end else begin
                  err_frames_d = err_frames_q;
               end
               crc_d       = de ? crc_next_s : CRC_INIT;
               run_d       = de ? 16'd1 : 16'd0;
               lines_d     = 16'd0;
               size_flag_d = 1'b0;
            end else if (de) begin
               crc_d = crc_next_s;
               run_d = sat_inc16(run_q);
            end else if (line_end_s) begin
               lines_d = sat_inc16(lines_q);
               if (run_q != WIDTH_C) begin
                  size_flag_d = 1'b1;
               end else begin
                  size_flag_d = size_flag_q;
               end
               run_d = 16'd0;
            end else begin
               crc_d = crc_q;
            end
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   // State and result registers.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q      <= ST_IDLE;
         vsync_dly_q  <= 1'b0;
         de_dly_q     <= 1'b0;
         crc_q        <= CRC_INIT;
         run_q        <= 16'd0;
         lines_q      <= 16'd0;
         size_flag_q  <= 1'b0;
         frame_done_q <= 1'b0;
         frame_crc_q  <= CRC_INIT;
         crc_err_q    <= 1'b0;
         size_err_q   <= 1'b0;
         line_cnt_q   <= 16'd0;
         err_frames_q <= {ECW{1'b0}};
      end else begin
         state_q      <= state_d;
         vsync_dly_q  <= vsync_dly_d;
         de_dly_q     <= de_dly_d;
         crc_q        <= crc_d;
         run_q        <= run_d;
         lines_q      <= lines_d;
         size_flag_q  <= size_flag_d;
         frame_done_q <= frame_done_d;
         frame_crc_q  <= frame_crc_d;
         crc_err_q    <= crc_err_d;
         size_err_q   <= size_err_d;
         line_cnt_q   <= line_cnt_d;
         err_frames_q <= err_frames_d;
      end
   end

   assign frame_done = frame_done_q;
   assign frame_crc  = frame_crc_q;
   assign crc_err    = crc_err_q;
   assign size_err   = size_err_q;
   assign line_cnt   = line_cnt_q;
   assign err_frames = err_frames_q;

endmodule

// File: tb/tb_tcon_frame_crc_checker.sv
// Directed bench for tcon_frame_crc_checker with a small 4x2 frame geometry
// and a 2-bit error-frame counter.
module tb_tcon_frame_crc_checker;

   localparam int          DW     = 8;
   localparam int          CH     = 3;
   localparam int          WIDTH  = 4;
   localparam int          HEIGHT = 2;
   localparam int          ECW    = 2;
   localparam logic [31:0] POLY   = 32'h04C1_1DB7;
   localparam logic [31:0] INIT   = 32'hFFFF_FFFF;

   logic              clk = 1'b0;
   logic              rst;
   logic              vsync;
   logic              de;
   logic [CH*DW-1:0]  pix_in;
   logic              chk_en;
   logic [31:0]       exp_crc;
   logic              frame_done;
   logic [31:0]       frame_crc;
   logic              crc_err;
   logic              size_err;
   logic [15:0]       line_cnt;
   logic [ECW-1:0]    err_frames;

   int          checks = 0;
   int          errors = 0;
   int          k_ramp = 0;
   logic [31:0] model;
   logic [31:0] gold;

   always #5 clk = ~clk;

   tcon_frame_crc_checker #(
      .DW(DW), .CH(CH), .WIDTH(WIDTH), .HEIGHT(HEIGHT), .ECW(ECW)
   ) dut (
      .clk(clk), .rst(rst), .vsync(vsync), .de(de), .pix_in(pix_in),
      .chk_en(chk_en), .exp_crc(exp_crc), .frame_done(frame_done),
      .frame_crc(frame_crc), .crc_err(crc_err), .size_err(size_err),
      .line_cnt(line_cnt), .err_frames(err_frames)
   );

   // Byte-wise CRC-32/MPEG-2 step over a 24-bit pixel, top byte first.
   function automatic logic [31:0] crc_px(input logic [31:0] c_in, input logic [23:0] px);
      logic [31:0] c;
      c = c_in;
      for (int b = 2; b >= 0; b--) begin
         c = c ^ {px[8*b +: 8], 24'h000000};
         for (int k = 0; k < 8; k++) begin
            if (c[31]) c = {c[30:0], 1'b0} ^ POLY;
            else       c = {c[30:0], 1'b0};
         end
      end
      return c;
   endfunction

   function automatic logic [23:0] ramp_px(input int k);
      return {8'(3*k + 2), 8'(3*k + 1), 8'(3*k)};
   endfunction

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
      checks++;
      assert (obs === expv) else begin
         errors++;
         $error("FAIL %s observed %h expected %h", tag, obs, expv);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic put_px(input logic [23:0] p);
      de     = 1'b1;
      pix_in = p;
      model  = crc_px(model, p);
      tick();
   endtask

   task automatic idle(input int n);
      de     = 1'b0;
      pix_in = 24'h000000;
      repeat (n) tick();
   endtask

   task automatic ramp_line(input int n);
      for (int i = 0; i < n; i++) begin
         put_px(ramp_px(k_ramp));
         k_ramp++;
      end
      idle(2);
   endtask

   task automatic close_frame(input logic c_en, input logic [31:0] e,
                              input logic dfb, input logic [23:0] p);
      vsync   = 1'b1;
      chk_en  = c_en;
      exp_crc = e;
      gold    = model;
      if (dfb) begin
         de     = 1'b1;
         pix_in = p;
      end else begin
         de     = 1'b0;
         pix_in = 24'h000000;
      end
      tick();
      model = dfb ? crc_px(INIT, p) : INIT;
   endtask

   task automatic expect_frame(input string tag, input logic [31:0] crc,
                               input logic ce, input logic se,
                               input logic [15:0] lc, input logic [ECW-1:0] ef);
      check({tag, "_done"},    32'(frame_done), 32'd1);
      check({tag, "_crc"},     frame_crc,       crc);
      check({tag, "_crc_err"}, 32'(crc_err),    32'(ce));
      check({tag, "_size"},    32'(size_err),   32'(se));
      check({tag, "_lines"},   32'(line_cnt),   32'(lc));
      check({tag, "_errfr"},   32'(err_frames), 32'(ef));
      vsync  = 1'b0;
      chk_en = 1'b0;
   endtask

   task automatic check_reset(input string tag);
      check({tag, "_done"},    32'(frame_done), 32'd0);
      check({tag, "_crc"},     frame_crc,       INIT);
      check({tag, "_crc_err"}, 32'(crc_err),    32'd0);
      check({tag, "_size"},    32'(size_err),   32'd0);
      check({tag, "_lines"},   32'(line_cnt),   32'd0);
      check({tag, "_errfr"},   32'(err_frames), 32'd0);
   endtask

   initial begin
      rst = 1'b1; vsync = 1'b0; de = 1'b0; chk_en = 1'b0;
      pix_in = 24'h000000; exp_crc = 32'h0; model = INIT; gold = INIT;
      repeat (3) @(posedge clk);
      #1;
      check_reset("reset");
      rst = 1'b0;
      tick();

      // Pixels before the first boundary are ignored.
      put_px(24'hABCDEF);
      put_px(24'h123456);
      idle(2);

      // First boundary only opens a frame.
      vsync = 1'b1;
      tick();
      check("first_fb_done", 32'(frame_done), 32'd0);
      vsync = 1'b0;
      tick();
      check("first_fb_done2", 32'(frame_done), 32'd0);
      check("first_fb_crc", frame_crc, INIT);
      model = INIT;

      // A: good frame, matching expected signature.
      ramp_line(4); ramp_line(4);
      close_frame(1'b1, model, 1'b0, 24'h0);
      expect_frame("A", gold, 1'b0, 1'b0, 16'd2, 2'd0);
      tick();
      check("A_pulse_low", 32'(frame_done), 32'd0);
      check("A_crc_hold", frame_crc, gold);

      // B: same frame, wrong expected signature.
      k_ramp = 0;
      ramp_line(4); ramp_line(4);
      close_frame(1'b1, model ^ 32'h1, 1'b0, 24'h0);
      expect_frame("B", gold, 1'b1, 1'b0, 16'd2, 2'd1);
      tick();

      // C: wrong expected signature but comparison disabled.
      k_ramp = 0;
      ramp_line(4); ramp_line(4);
      close_frame(1'b0, model ^ 32'h1, 1'b0, 24'h0);
      expect_frame("C", gold, 1'b0, 1'b0, 16'd2, 2'd1);
      tick();

      // D: short first line.
      ramp_line(3); ramp_line(4);
      close_frame(1'b0, 32'h0, 1'b0, 24'h0);
      expect_frame("D", gold, 1'b0, 1'b1, 16'd2, 2'd2);
      tick();

      // E: one line too many.
      ramp_line(4); ramp_line(4); ramp_line(4);
      close_frame(1'b0, 32'h0, 1'b0, 24'h0);
      expect_frame("E", gold, 1'b0, 1'b1, 16'd3, 2'd3);
      tick();

      // F: second line still open at the boundary, and de high on that cycle.
      ramp_line(4);
      for (int i = 0; i < 4; i++) begin
         put_px(ramp_px(k_ramp));
         k_ramp++;
      end
      close_frame(1'b1, model, 1'b1, 24'hC0FFEE);
      expect_frame("F", gold, 1'b0, 1'b0, 16'd2, 2'd3);

      // G: frame whose first pixel arrived on the boundary cycle.
      for (int i = 0; i < 3; i++) begin
         put_px(ramp_px(k_ramp));
         k_ramp++;
      end
      idle(2);
      ramp_line(4);
      close_frame(1'b1, model, 1'b0, 24'h0);
      expect_frame("G", gold, 1'b0, 1'b0, 16'd2, 2'd3);
      tick();

      // H: "123456789" as three pixels; known CRC-32/MPEG-2 check value.
      put_px(24'h313233); put_px(24'h343536); put_px(24'h373839);
      idle(2);
      close_frame(1'b1, 32'h0376_E6E7, 1'b0, 24'h0);
      expect_frame("H", 32'h0376_E6E7, 1'b0, 1'b1, 16'd1, 2'd3);
      tick();

      // I: bad signature, counter stays saturated.
      ramp_line(4); ramp_line(4);
      close_frame(1'b1, ~model, 1'b0, 24'h0);
      expect_frame("I", gold, 1'b1, 1'b0, 16'd2, 2'd3);
      tick();

      // Reset in the middle of a frame.
      put_px(ramp_px(1)); put_px(ramp_px(2));
      rst = 1'b1;
      #1;
      check_reset("midrst");
      tick();
      rst = 1'b0;
      de  = 1'b0;
      tick();
      vsync = 1'b1;
      tick();
      check("postrst_fb_done", 32'(frame_done), 32'd0);
      vsync = 1'b0;
      tick();
      check("postrst_fb_done2", 32'(frame_done), 32'd0);
      model = INIT;

      // J: normal frame after reset.
      ramp_line(4); ramp_line(4);
      close_frame(1'b1, model, 1'b0, 24'h0);
      expect_frame("J", gold, 1'b0, 1'b0, 16'd2, 2'd0);
      tick();

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
